// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and produces every datapath enable, mux select and the 4-bit ALU operation.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic [3:0]       alu_ctrl,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALU_WB   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [3:0] ALU_IDLE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;

    logic [3:0]       state_q, state_d;
    logic             reg_dst_q, reg_dst_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [5:0]       opcode_s;
    logic [5:0]       funct_s;
    logic [3:0]       r_alu_s;
    logic [3:0]       i_alu_s;
    logic             unused_instr_s;

    // R-type funct to ALU op; ALU_IDLE marks an unsupported funct.
    function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
        case (funct)
            6'b100000: funct_to_alu = ALU_ADD;
            6'b100010: funct_to_alu = ALU_SUB;
            6'b100100: funct_to_alu = ALU_AND;
            6'b100101: funct_to_alu = ALU_OR;
            6'b100111: funct_to_alu = ALU_NOR;
            6'b101010: funct_to_alu = ALU_SLT;
            default:   funct_to_alu = ALU_IDLE;
        endcase
    endfunction

    function automatic logic [3:0] imm_to_alu(input logic [5:0] op);
        case (op)
            OP_ADDI: imm_to_alu = ALU_ADD;
            OP_ANDI: imm_to_alu = ALU_AND;
            OP_ORI:  imm_to_alu = ALU_OR;
            OP_SLTI: imm_to_alu = ALU_SLT;
            default: imm_to_alu = ALU_IDLE;
        endcase
    endfunction

    assign opcode_s       = instr[31:26];
    assign funct_s        = instr[5:0];
    assign r_alu_s        = funct_to_alu(funct_s);
    assign i_alu_s        = imm_to_alu(opcode_s);
    assign unused_instr_s = ^instr[25:6];

    // Next-state, writeback-destination flag and retirement counter.
    always_comb begin
        state_d   = state_q;
        reg_dst_d = reg_dst_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_RTYPE:                          state_d = S_EXEC_R;
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                    default:                           state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                if (r_alu_s == ALU_IDLE) begin
                    state_d = S_FETCH;
                end else begin
                    state_d   = S_ALU_WB;
                    reg_dst_d = 1'b1;
                end
            end
            S_EXEC_I: begin
                state_d   = S_ALU_WB;
                reg_dst_d = 1'b0;
            end
            S_MEM_ADDR: begin
                if (opcode_s == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
                state_d   = S_FETCH;
                retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, destination flag and retired counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            reg_dst_q <= 1'b0;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            reg_dst_q <= reg_dst_d;
            retired_q <= retired_d;
        end
    end

    // Control outputs; everything is held low while rst is high so no partial write escapes.
    always_comb begin
        alu_ctrl   = ALU_IDLE;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        if (rst) begin
            alu_ctrl = ALU_IDLE;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                    case (opcode_s)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: illegal = 1'b0;
                        default:                           illegal = 1'b1;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b00;
                    alu_ctrl  = r_alu_s;
                    illegal   = (r_alu_s == ALU_IDLE);
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = i_alu_s;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = reg_dst_q;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 2'b01;
                    if (opcode_s == OP_BNE) begin
                        pc_en = ~alu_zero;
                    end else begin
                        pc_en = alu_zero;
                    end
                end
                S_JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: begin
                    alu_ctrl = ALU_IDLE;
                end
            endcase
        end
    end

    assign retired = rst ? {CNT_W{1'b0}} : retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: a per-instruction reference model plans each cycle's inputs
// and expected controls; a negedge monitor pops and compares every cycle.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [3:0]       alu_ctrl;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic             pc_en;
        logic [1:0]       pc_src;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             reg_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             illegal;
        logic [CNT_W-1:0] retired;
    } ctl_t;

    typedef struct packed {
        logic        rst;
        logic        ready;
        logic        zero;
        logic [31:0] ins;
        ctl_t        exp;
        ctl_t        care;
    } step_t;

    typedef struct packed {
        ctl_t exp;
        ctl_t care;
    } chk_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      instr = 32'h0;
    logic             alu_zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic [3:0]       alu_ctrl;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_en(pc_en),
        .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    step_t            plan[$];
    chk_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    logic [CNT_W-1:0] m_ret = '0;
    logic [31:0]      cur_ins;
    int               n_emit;
    int               n_cut;

    function automatic ctl_t base_care();
        ctl_t c = '0;
        c.pc_en = 1'b1; c.mem_read = 1'b1; c.mem_write = 1'b1; c.ir_write = 1'b1;
        c.reg_write = 1'b1; c.illegal = 1'b1; c.retired = '1;
        return c;
    endfunction

    function automatic logic [3:0] r_op(input logic [5:0] fn);
        case (fn)
            6'h20: return 4'b0001;
            6'h22: return 4'b0010;
            6'h24: return 4'b0011;
            6'h25: return 4'b0100;
            6'h27: return 4'b0101;
            6'h2A: return 4'b0110;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic emit(input logic rdy, input logic z, input ctl_t e, input ctl_t c);
        step_t s;
        if (n_emit < n_cut) begin
            e.retired = m_ret;
            s.rst = 1'b0; s.ready = rdy; s.zero = z; s.ins = cur_ins; s.exp = e; s.care = c;
            plan.push_back(s);
        end
        n_emit++;
    endtask

    task automatic push_reset(input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s.rst = 1'b1; s.ready = 1'($urandom_range(0, 1)); s.zero = 1'($urandom_range(0, 1));
            s.ins = $urandom; s.exp = '0; s.care = '1;
            plan.push_back(s);
        end
        m_ret = '0;
    endtask

    // One instruction: wf/wm = not-ready cycles in fetch/memory, zsel<0 random alu_zero.
    task automatic gen_instr(input logic [31:0] ins, input int wf, input int wm,
                             input int zsel, input int cut);
        ctl_t e, c;
        logic z;
        logic [5:0] op = ins[31:26];
        logic [3:0] ia;
        cur_ins = ins; n_emit = 0; n_cut = cut;
        for (int i = 0; i <= wf; i++) begin
            e = '0; c = base_care();
            e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_ctrl = 4'b0001;
            e.ir_write = (i == wf); e.pc_en = (i == wf);
            c.iord = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_ctrl = 4'hF; c.pc_src = 2'b11;
            emit(i == wf, 1'($urandom_range(0, 1)), e, c);
        end
        e = '0; c = base_care();
        e.alu_src_b = 2'b11; e.alu_ctrl = 4'b0001;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_ctrl = 4'hF;
        case (op)
            6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A: e.illegal = 1'b0;
            default: e.illegal = 1'b1;
        endcase
        emit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, c);
        if (e.illegal) return;
        e = '0; c = base_care();
        case (op)
            6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A: begin
                case (op)
                    6'h08:   ia = 4'b0001;
                    6'h0C:   ia = 4'b0011;
                    6'h0D:   ia = 4'b0100;
                    6'h0A:   ia = 4'b0110;
                    default: ia = r_op(ins[5:0]);
                endcase
                e.alu_src_a = 1'b1; e.alu_src_b = (op == 6'h00) ? 2'b00 : 2'b10; e.alu_ctrl = ia;
                e.illegal = (ia == 4'b0000);
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_ctrl = 4'hF;
                emit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, c);
                if (e.illegal) return;
                e = '0; c = base_care();
                e.reg_write = 1'b1; e.reg_dst = (op == 6'h00);
                c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
                emit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, c);
            end
            6'h23, 6'h2B: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = 4'b0001;
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_ctrl = 4'hF;
                emit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, c);
                for (int i = 0; i <= wm; i++) begin
                    e = '0; c = base_care();
                    e.mem_read = (op == 6'h23); e.mem_write = (op == 6'h2B); e.iord = 1'b1;
                    c.iord = 1'b1;
                    emit(i == wm, 1'($urandom_range(0, 1)), e, c);
                end
                if (op == 6'h23) begin
                    e = '0; c = base_care();
                    e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
                    emit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, c);
                end
            end
            6'h04, 6'h05: begin
                z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
                e.alu_src_a = 1'b1; e.alu_ctrl = 4'b0010; e.pc_src = 2'b01;
                e.pc_en = (op == 6'h04) ? z : !z;
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_ctrl = 4'hF; c.pc_src = 2'b11;
                emit(1'($urandom_range(0, 1)), z, e, c);
            end
            default: begin
                e.pc_src = 2'b10; e.pc_en = 1'b1; c.pc_src = 2'b11;
                emit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, c);
            end
        endcase
        if (n_emit <= n_cut) m_ret = m_ret + 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 12))
            0, 1, 2: begin
                r[31:26] = 6'h00;
                case ($urandom_range(0, 6))
                    0: r[5:0] = 6'h20;
                    1: r[5:0] = 6'h22;
                    2: r[5:0] = 6'h24;
                    3: r[5:0] = 6'h25;
                    4: r[5:0] = 6'h27;
                    5: r[5:0] = 6'h2A;
                    default: r[5:0] = 6'($urandom);
                endcase
            end
            3:  r[31:26] = 6'h23;
            4:  r[31:26] = 6'h2B;
            5:  r[31:26] = 6'h04;
            6:  r[31:26] = 6'h05;
            7:  r[31:26] = 6'h02;
            8:  r[31:26] = 6'h08;
            9:  r[31:26] = 6'h0C;
            10: r[31:26] = 6'h0D;
            11: r[31:26] = 6'h0A;
            default: r[31:26] = 6'($urandom);
        endcase
        return r;
    endfunction

    // Monitor: every cycle with a pending expectation is compared on the falling edge.
    always @(negedge clk) begin
        ctl_t act;
        chk_t k;
        cyc++;
        if (sb.size() > 0) begin
            k = sb.pop_front();
            act.alu_ctrl = alu_ctrl; act.alu_src_a = alu_src_a; act.alu_src_b = alu_src_b;
            act.pc_en = pc_en; act.pc_src = pc_src; act.iord = iord; act.mem_read = mem_read;
            act.mem_write = mem_write; act.ir_write = ir_write; act.reg_write = reg_write;
            act.reg_dst = reg_dst; act.mem_to_reg = mem_to_reg; act.illegal = illegal;
            act.retired = retired;
            checks++;
            if (((act ^ k.exp) & k.care) != '0) begin
                errors++;
                $display("FAIL ctl cycle %0d: got %h want %h (care %h)", cyc, act, k.exp, k.care);
            end
        end
    end

    initial begin
        step_t s;
        push_reset(2);
        gen_instr(32'h00851020, 0, 0, -1, 1000);
        gen_instr(32'h8C820004, 0, 3, -1, 1000);
        gen_instr(32'h10850003, 0, 0, 1, 1000);
        gen_instr(32'h10850003, 1, 0, 0, 1000);
        gen_instr(32'h14850003, 0, 0, 0, 1000);
        gen_instr(32'h0085103F, 0, 0, -1, 1000);
        gen_instr(32'hFC000000, 0, 0, -1, 1000);
        gen_instr(32'h8C820004, 0, 5, -1, 5);
        push_reset(2);
        for (int i = 0; i < 15; i++) begin
            case (i % 5)
                0: gen_instr(32'hAC820008, 0, i % 3, -1, 1000);
                1: gen_instr(32'h20850007, 0, 0, -1, 1000);
                2: gen_instr(32'h00851022, i % 2, 0, -1, 1000);
                3: gen_instr(32'h14850003, 0, 0, -1, 1000);
                default: gen_instr(32'h3485000F, 0, 0, -1, 1000);
            endcase
        end
        gen_instr(32'h08000010, 0, 0, -1, 1000);
        for (int i = 0; i < 80; i++) begin
            gen_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), -1, 1000);
        end
        gen_instr(32'h00851020, 0, 0, -1, 1000);
        while (plan.size() > 0) begin
            @(posedge clk);
            #1;
            s = plan.pop_front();
            rst = s.rst; mem_ready = s.ready; alu_zero = s.zero; instr = s.ins;
            sb.push_back({s.exp, s.care});
        end
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, wanted 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS control FSM that drives the 4-bit ALU operation code and consumes the ALU zero flag.
- Sequences fetch/decode/execute/memory/writeback and produces every datapath enable and mux select.
- Uses a ready handshake with unified instruction/data memory.
- Sits between the instruction register, the ALU and the memory port.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- instr  input  32  instruction register contents; stable from DECODE until return to FETCH
- alu_zero  input  1  ALU zero flag for the current alu_ctrl
- mem_ready  input  1  memory completes current read/write this cycle
- alu_ctrl  output  4  0001 add, 0010 sub, 0011 and, 0100 or, 0101 nor, 0110 set-less-than, 0000 idle
- alu_src_a  output  1  0=PC, 1=rs register
- alu_src_b  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pc_en  output  1  load PC this cycle
- pc_src  output  2  00=ALU result, 01=ALUOut register, 10=jump target {PC[31:28],instr[25:0],00}
- iord  output  1  0=memory address from PC, 1=from ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  latch memory data into IR
- reg_write  output  1  register file write
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALUOut, 1=memory data register
- illegal  output  1  one-cycle pulse on unsupported opcode/funct
- retired  output  CNT_W  count of completed instructions

Behaviour:
- States (4-bit): FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP.
- rst high: next state FETCH, retired=0. All outputs forced 0 (alu_ctrl=0000) during any cycle with rst high, including reset mid-instruction; no partial writes may occur.
- Outputs decode combinationally from the state register, plus instr, alu_zero and mem_ready where noted.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=0001, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - Stay in FETCH until mem_ready; then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=0001 (branch target into ALUOut). Next state by instr[31:26]:
  - 000000 → EXEC_R
  - 100011/101011 → MEM_ADDR
  - 000100/000101 → BRANCH
  - 000010 → JUMP
  - 001000/001100/001101/001010 → EXEC_I
  - else → illegal=1 this cycle, next FETCH; retired not incremented.
- EXEC_R:
  - alu_src_a=1, alu_src_b=00; alu_ctrl from funct: 100000→0001, 100010→0010, 100100→0011, 100101→0100, 100111→0101, 101010→0110.
  - Unknown funct → illegal pulse, next FETCH, no reg_write.
  - Valid funct → ALU_WB with reg_dst=1.
- EXEC_I:
  - alu_src_a=1, alu_src_b=10.
  - addi→0001, andi→0011, ori→0100, slti→0110.
  - Next ALU_WB with reg_dst=0.
  - reg_dst is held from a registered flag set in EXEC_R/EXEC_I.
- ALU_WB: reg_write=1, mem_to_reg=0; next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=0001; next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, iord=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready, then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_ctrl=0010, pc_src=01.
  - pc_en=alu_zero for beq, pc_en=~alu_zero for bne.
  - Next FETCH.
- JUMP: pc_src=10, pc_en=1; next FETCH.
- mem_read and mem_write are never both high. A request holds constant, with a stable address select, until mem_ready. mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- retired increments by 1 on each transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP. It wraps modulo 2^CNT_W.
- Zero-wait latency (FETCH through last state): R/I-type 4, lw 5, sw 4, beq/bne 3, j 3 cycles.

Test Plan:
- Reset mid-MEM_RD with mem_ready=0 → outputs all 0 during rst; after release, first cycle is FETCH with mem_read=1, iord=0, alu_ctrl=0001; retired=0.
- instr=0x00851020 (add $2,$4,$5), mem_ready=1 → FETCH, DECODE, EXEC_R (alu_ctrl=0001, alu_src_b=00), ALU_WB (reg_write=1, reg_dst=1); retired=1 after 4 cycles.
- lw 0x8C820004 with mem_ready low 3 cycles in MEM_RD → mem_read=1, iord=1 held 4 cycles; MEM_WB asserts reg_write=1, mem_to_reg=1; total 8 cycles.
- beq 0x10850003: alu_zero=1 → BRANCH pc_en=1, pc_src=01, alu_ctrl=0010; repeat with alu_zero=0 → pc_en=0; bne with alu_zero=0 → pc_en=1.
- funct 111111 under opcode 0 → illegal high exactly one cycle in EXEC_R, reg_write never asserted, retired unchanged; opcode 111111 → illegal in DECODE.
- Preload retired to 2^CNT_W−1 (CNT_W=4 build: 15), execute j 0x08000010 → pc_en=1, pc_src=10; retired wraps to 0.
